fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshake.
//  Generalised successor to the single-precision combinational adder: configurable exponent/mantissa width,
//  add/sub mode, round-to-nearest-even, special-value handling and exception flags.
//  Sits between the FPU issue logic and the FPU result writeback.
// PARAMETERS
//  EXP_W   8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W   23  stored mantissa width (hidden bit excluded); EXP_W=8/MAN_W=23 is binary32
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              operand beat valid
//  in_ready   out  1              block accepts beat this cycle
//  in_a       in   1+EXP_W+MAN_W  operand A {sign,exp,man}
//  in_b       in   1+EXP_W+MAN_W  operand B
//  in_sub     in   1              1: A-B (B sign inverted), 0: A+B
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  out_res    out  1+EXP_W+MAN_W  rounded result
//  out_flags  out  4              {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0, out_res=0, out_flags=0; in_ready=1 one cycle after rst released.
//  - Global stall: adv = ~out_valid | out_ready; in_ready = adv. All stages shift only when adv=1.
//    Beat accepted when in_valid & in_ready. Latency exactly 3 cycles with no stall: accepted at edge N -> out_valid at N+3.
//    Throughput 1/cycle. out_res/out_flags hold stable while out_valid & ~out_ready. Bubbles propagate (valid=0).
//  - S1 align: unpack, hidden bit = (exp!=0). Exp==0 inputs treated as signed zero (DAZ).
//    Swap so |A|>=|B| (compare {exp,man}). d=expA-expB.
//    Shift B mantissa right by d into MAN_W+4 bits {hidden,man,G,R,S}; shifted-out bits OR into S.
//    If d >= MAN_W+3, B becomes sticky only. Eff_sub = signA ^ signB ^ in_sub.
//  - S2 add: MAN_W+5-bit add or subtract (big - small, never negative after swap). Result sign = sign of larger.
//    Exact zero from sub -> +0 (RNE); (-0)+(-0) -> -0.
//  - S3 normalise/round: carry -> shift right 1, exp+1, fold bit into S.
//    Else left shift by leading-zero count (limited so exp>=1). RNE on G,R,S: round up if G&(R|S|lsb).
//    Mantissa overflow from rounding -> exp+1.
//    exp >= 2**EXP_W-1 -> +/-inf, overflow=1, inexact=1. Result exp <= 0 -> signed zero, underflow=1, inexact=1 (FTZ).
//    inexact = G|R|S before rounding.
//  - Specials (detected S1, carried as tag, override S3):
//    any NaN -> canonical qNaN {0,all-1 exp,1,0..}, invalid=1 only if a NaN is signalling (man MSB=0).
//    inf op -inf (effective) -> qNaN, invalid=1. inf op finite -> that inf, no flags.
//  - rst asserted mid-operation: all in-flight beats discarded, no output for them.
//  - Widths: all internal exponent math on EXP_W+2 signed bits to avoid wrap.
// STRUCTURE
//  - fpu_pkg: EXP_W/MAN_W-derived localparams (BIAS, EXP_MAX), canonical qNaN constant,
//    fp_flags_t struct {invalid,overflow,underflow,inexact}, special-class enum {NORMAL,ZERO,INF,QNAN,SNAN}.
//  - Sub-module fp_lzc #(W): combinational leading-zero counter used in S3; everything else inline.
//  - Pipeline registers per stage: valid, sign, exp, mantissa+GRS, special tag, eff_sub.
// TESTING (binary32 defaults)
//  1. A=0x3F800000, B=0x3F800000, sub=0 -> 3 cycles later res=0x40000000, flags=0.
//  2. A=0x3F800000, B=0x3F800000, sub=1 -> res=0x00000000; A=0x80000000+B=0x80000000 -> 0x80000000.
//  3. A=0x3F800000, B=0x33800000 (2^-24, tie) -> res=0x3F800000, inexact=1; B=0x33800001 -> 0x3F800001.
//  4. A=0x7F800000, B=0xFF800000 -> 0x7FC00000 invalid=1; A=0x7F7FFFFF+B=0x7F7FFFFF -> 0x7F800000 overflow=1, inexact=1.
//  5. Stream 8 back-to-back beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, no beat lost/duplicated, order kept.
//  6. Assert rst with 3 beats in flight -> out_valid=0 next cycle, none of them ever emitted; random reference-model compare 10k ops.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the FPU datapath: default binary32 widths,
// derived constants, exception flag layout and operand classification.
package fpu_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_BIAS    = 2**(FP_EXP_W-1) - 1;
  localparam int FP_EXP_MAX = 2**FP_EXP_W - 1;

  localparam logic [FP_EXP_W+FP_MAN_W:0] FP_QNAN =
    {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W with o_zero set.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  i_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_val[i]) o_cnt = CW'(W - 1 - i);
    end
  end

  assign o_zero = ~|i_val;

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754 adder/subtractor: input capture, align, add, normalise/round.
// One global advance signal stalls every stage together when the output is blocked.
module fp_add_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [3:0]           out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + 4;            // {hidden, man, G, R, S}
  localparam int SW = MAN_W + 5;
  localparam int XW = EXP_W + 2;
  localparam int RW = MAN_W + 2;
  localparam int CW = $clog2(FW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] D_SAT    = EXP_W'(FW - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    fp_class_t c;
    c = CLS_NORMAL;
    if (e == EXP_ONES) begin
      if (m == '0)          c = CLS_INF;
      else if (m[MAN_W-1])  c = CLS_QNAN;
      else                  c = CLS_SNAN;
    end else if (e == '0) begin
      c = CLS_ZERO;
    end
    return c;
  endfunction

  logic w_adv;
  logic r0_valid, r0_sub;
  logic [W-1:0] r0_a, r0_b;
  logic r1_valid, r1_sign, r1_eff_sub, r1_inv;
  logic [EXP_W-1:0] r1_exp;
  logic [FW-1:0] r1_mbig, r1_msml;
  fp_class_t r1_tag;
  logic r2_valid, r2_sign, r2_inv;
  logic [EXP_W-1:0] r2_exp;
  logic [SW-1:0] r2_sum;
  fp_class_t r2_tag;
  logic r3_valid;
  logic [W-1:0] r3_res;
  fp_flags_t r3_flags;

  assign w_adv     = ~r3_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r3_valid;
  assign out_res   = r3_res;
  assign out_flags = r3_flags;

  // Align: denormal inputs are flushed to signed zero before the magnitude compare
  logic w_sa, w_sb, w_swap, w_s_big, w_inv, w_tag_sign;
  logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_sml, w_d;
  logic [MAN_W-1:0] w_ma, w_mb, w_m_big, w_m_sml;
  logic [FW-1:0] w_ext_sml, w_mask, w_aligned;
  fp_class_t w_cls_a, w_cls_b, w_tag;

  assign w_sa      = r0_a[W-1];
  assign w_sb      = r0_b[W-1] ^ r0_sub;
  assign w_ea      = r0_a[W-2:MAN_W];
  assign w_eb      = r0_b[W-2:MAN_W];
  assign w_ma      = (w_ea == '0) ? '0 : r0_a[MAN_W-1:0];
  assign w_mb      = (w_eb == '0) ? '0 : r0_b[MAN_W-1:0];
  assign w_cls_a   = classify(w_ea, r0_a[MAN_W-1:0]);
  assign w_cls_b   = classify(w_eb, r0_b[MAN_W-1:0]);
  assign w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_s_big   = w_swap ? w_sb : w_sa;
  assign w_e_big   = w_swap ? w_eb : w_ea;
  assign w_e_sml   = w_swap ? w_ea : w_eb;
  assign w_m_big   = w_swap ? w_mb : w_ma;
  assign w_m_sml   = w_swap ? w_ma : w_mb;
  assign w_d       = w_e_big - w_e_sml;
  assign w_ext_sml = {w_e_sml != '0, w_m_sml, 3'b000};
  assign w_mask    = (FW'(1) << w_d) - FW'(1);

  always_comb begin
    if (w_d >= D_SAT) w_aligned = {{(FW-1){1'b0}}, |w_ext_sml};
    else              w_aligned = (w_ext_sml >> w_d) | {{(FW-1){1'b0}}, |(w_ext_sml & w_mask)};
  end

  always_comb begin
    w_tag      = CLS_NORMAL;
    w_inv      = 1'b0;
    w_tag_sign = w_s_big;
    if (w_cls_a inside {CLS_QNAN, CLS_SNAN} || w_cls_b inside {CLS_QNAN, CLS_SNAN}) begin
      w_tag = CLS_QNAN;
      w_inv = (w_cls_a == CLS_SNAN) | (w_cls_b == CLS_SNAN);
    end else if (w_cls_a == CLS_INF && w_cls_b == CLS_INF) begin
      w_tag      = (w_sa != w_sb) ? CLS_QNAN : CLS_INF;
      w_inv      = (w_sa != w_sb);
      w_tag_sign = w_sa;
    end else if (w_cls_a == CLS_INF) begin
      w_tag      = CLS_INF;
      w_tag_sign = w_sa;
    end else if (w_cls_b == CLS_INF) begin
      w_tag      = CLS_INF;
      w_tag_sign = w_sb;
    end
  end

  // Add: operands are ordered so the subtraction never goes negative
  logic [SW-1:0] w_sum;
  assign w_sum = r1_eff_sub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                            : ({1'b0, r1_mbig} + {1'b0, r1_msml});

  // Normalise and round to nearest even
  logic [CW-1:0] w_lzc;
  logic w_sum_zero, w_carry, w_rnd_up;
  logic [FW-1:0] w_norm;
  logic [XW-1:0] w_exp_n, w_exp_f;
  logic [RW-1:0] w_mant_r;
  logic [W-1:0] w_res;
  fp_flags_t w_flags;

  fp_lzc #(.W(FW), .CW(CW)) u_lzc (
    .i_val  (r2_sum[FW-1:0]),
    .o_cnt  (w_lzc),
    .o_zero (w_sum_zero)
  );

  assign w_carry = r2_sum[SW-1];

  always_comb begin
    if (w_carry) begin
      w_norm  = {r2_sum[SW-1:2], |r2_sum[1:0]};
      w_exp_n = {2'b00, r2_exp} + XW'(1);
    end else begin
      w_norm  = r2_sum[FW-1:0] << w_lzc;
      w_exp_n = {2'b00, r2_exp} - XW'(w_lzc);
    end
  end

  assign w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mant_r = {1'b0, w_norm[FW-1:3]} + RW'(w_rnd_up);
  assign w_exp_f  = w_exp_n + XW'(w_mant_r[RW-1]);

  always_comb begin
    w_res           = {r2_sign, w_exp_f[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
    w_flags         = '0;
    w_flags.inexact = |w_norm[2:0];
    if (r2_tag == CLS_QNAN) begin
      w_res           = QNAN;
      w_flags         = '0;
      w_flags.invalid = r2_inv;
    end else if (r2_tag == CLS_INF) begin
      w_res   = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flags = '0;
    end else if (w_sum_zero && !w_carry) begin
      w_res   = {r2_sign, {(W-1){1'b0}}};
      w_flags = '0;
    end else if (w_exp_n[XW-1] || w_exp_n == '0) begin
      w_res             = {r2_sign, {(W-1){1'b0}}};
      w_flags.underflow = 1'b1;
      w_flags.inexact   = 1'b1;
    end else if (w_exp_f >= {2'b00, EXP_ONES}) begin
      w_res            = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flags.overflow = 1'b1;
      w_flags.inexact  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
      r3_res   <= '0;
      r3_flags <= '0;
    end else if (w_adv) begin
      r0_valid <= in_valid;
      if (in_valid) begin
        r0_a   <= in_a;
        r0_b   <= in_b;
        r0_sub <= in_sub;
      end
      r1_valid <= r0_valid;
      if (r0_valid) begin
        r1_sign    <= w_tag_sign;
        r1_exp     <= w_e_big;
        r1_mbig    <= {w_e_big != '0, w_m_big, 3'b000};
        r1_msml    <= w_aligned;
        r1_eff_sub <= w_sa ^ w_sb;
        r1_tag     <= w_tag;
        r1_inv     <= w_inv;
      end
      r2_valid <= r1_valid;
      if (r1_valid) begin
        // exact cancellation rounds to +0 under nearest-even
        r2_sign <= (r1_tag == CLS_NORMAL && r1_eff_sub && w_sum == '0) ? 1'b0 : r1_sign;
        r2_exp  <= r1_exp;
        r2_sum  <= w_sum;
        r2_tag  <= r1_tag;
        r2_inv  <= r1_inv;
      end
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_res   <= w_res;
        r3_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed and randomised check of fp_add_pipe (binary32) against an exact-integer reference.
module tb_fp_add_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0] out_flags;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flags;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } beat_t;

  vec_t  tbl[$];
  beat_t beats[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact reference: both operands as integers on a common grid, then RNE to 24 bits.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] res, output logic [3:0] fl);
    logic sa, sb, sr, nan_a, nan_b, inx;
    logic [7:0] ea, eb;
    logic [22:0] ma, mb;
    logic [299:0] va, vb, vs, rem, half;
    logic [24:0] m;
    int p, e;
    sa = a[31]; sb = b[31] ^ sub;
    ea = a[30:23]; eb = b[30:23];
    ma = a[22:0]; mb = b[22:0];
    fl = 4'b0000;
    nan_a = (ea == 8'hFF) && (ma != 0);
    nan_b = (eb == 8'hFF) && (mb != 0);
    if (nan_a || nan_b) begin
      res = FP_QNAN;
      fl[3] = (nan_a && !ma[22]) || (nan_b && !mb[22]);
      return;
    end
    if (ea == 8'hFF && eb == 8'hFF) begin
      if (sa != sb) begin res = FP_QNAN; fl = 4'b1000; end
      else res = {sa, 8'hFF, 23'h0};
      return;
    end
    if (ea == 8'hFF) begin res = {sa, 8'hFF, 23'h0}; return; end
    if (eb == 8'hFF) begin res = {sb, 8'hFF, 23'h0}; return; end
    va = (ea == 0) ? 300'(0) : (300'({1'b1, ma}) << (ea - 8'd1));
    vb = (eb == 0) ? 300'(0) : (300'({1'b1, mb}) << (eb - 8'd1));
    if (sa == sb)      begin vs = va + vb; sr = sa; end
    else if (va >= vb) begin vs = va - vb; sr = sa; end
    else               begin vs = vb - va; sr = sb; end
    if (vs == 0) begin
      res = {(sa == sb) ? sa : 1'b0, 31'h0};
      return;
    end
    p = 299;
    while (!vs[p]) p--;
    e = p - 22;
    if (e <= 0) begin
      res = {sr, 31'h0};
      fl = 4'b0011;
      return;
    end
    inx = 1'b0;
    if (p == 23) begin
      m = 25'(vs);
    end else begin
      m    = 25'(vs >> (p - 23));
      rem  = vs & ((300'(1) << (p - 23)) - 300'(1));
      half = 300'(1) << (p - 24);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    end
    if (m[24]) begin e++; m = m >> 1; end
    if (e >= 255) begin
      res = {sr, 8'hFF, 23'h0};
      fl = 4'b0101;
    end else begin
      res = {sr, 8'(e), m[22:0]};
      fl[0] = inx;
    end
  endfunction

  task automatic run_one(input vec_t v);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_sub = v.sub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
    chk({v.name, "_latency"}, 64'(lat), 64'd3);
    chk(v.name, {28'h0, out_flags, out_res}, {28'h0, v.flags, v.res});
  endtask

  task automatic run_stream(input int stall_from, input int stall_len, input bit rand_ready);
    int idx, cyc, got, limit;
    logic [35:0] expq[$];
    logic [35:0] e, prev;
    logic [31:0] r;
    logic [3:0] f;
    bit prev_stall;
    idx = 0; cyc = 0; got = 0; prev_stall = 0; prev = '0;
    limit = 40 * beats.size() + 100;
    while ((idx < beats.size() || expq.size() != 0) && cyc < limit) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 4) != 0);
      else            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (idx < beats.size()) begin
        in_valid = 1'b1; in_a = beats[idx].a; in_b = beats[idx].b; in_sub = beats[idx].sub;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (prev_stall) chk("stall_hold", 64'({out_flags, out_res}), 64'(prev));
        prev = {out_flags, out_res};
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("stream_extra", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("stream_res", 64'({out_flags, out_res}), 64'(e));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        ref_add(beats[idx].a, beats[idx].b, beats[idx].sub, r, f);
        expq.push_back({f, r});
        idx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'(beats.size()));
    chk("stream_drain", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_res",   64'(out_res),   64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);

    tbl.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, "one_plus_one"});
    tbl.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "one_minus_one"});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negzero_sum"});
    tbl.push_back('{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, "mixed_zero_sum"});
    tbl.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even_down"});
    tbl.push_back('{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, "above_tie_up"});
    tbl.push_back('{32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 4'b0000, "carry_exact"});
    tbl.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf_minus_inf"});
    tbl.push_back('{32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 4'b1000, "ninf_sub_ninf"});
    tbl.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf_plus_one"});
    tbl.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "one_sub_inf"});
    tbl.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "snan_in"});
    tbl.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "qnan_in"});
    tbl.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "max_plus_max"});
    tbl.push_back('{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101, "max_round_ovf"});
    tbl.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "three_minus_one"});
    tbl.push_back('{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000, "neg_one_plus_half"});
    tbl.push_back('{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000, "one_sub_negone"});
    tbl.push_back('{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, "denormal_daz"});
    tbl.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, "cancel_ftz"});
    foreach (tbl[i]) run_one(tbl[i]);

    // eight back-to-back beats with a five-cycle output stall in the middle
    beats.delete();
    for (int i = 0; i < 8; i++) beats.push_back('{32'h3F800000 + (32'(i) << 20), 32'h40000000, i[0]});
    run_stream(4, 5, 1'b0);

    // three beats in flight when reset hits
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000 + (32'(i) << 21); in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_flush_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_emit", 64'(seen), 64'd0);

    beats.delete();
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1, 2: rb = {rb[31], ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3, rb[22:0]};
        3: rb = ra ^ (32'h1 << $urandom_range(0, 22)) ^ 32'h80000000;
        default: begin
          ra = {ra[31], 8'hFE, ra[22:0]};
          rb = {rb[31], 8'hFE - 8'($urandom_range(0, 30)), rb[22:0]};
        end
      endcase
      beats.push_back('{ra, rb, 1'($urandom_range(0, 1))});
    end
    run_stream(0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
